// File: rtl/instr_encoder.sv
// RV32I field-bundle encoder feeding the instruction-memory write port.
// Encodes per major opcode, buffers up to two words, writes them to sequential addresses.
module instr_encoder #(
  parameter int          ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            opcode,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [2:0]            funct3,
  input  logic                  funct7,
  input  logic [31:0]           imm,
  input  logic                  flush,
  output logic                  wr_en,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  err,
  output logic                  ovf
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] TOP  = {ADDR_WIDTH{1'b1}};

  logic [31:0] enc;
  logic        supported;
  logic [6:0]  f7;
  logic        unused_imm;

  logic [31:0] fifo_mem [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic        accept;
  logic        push;
  logic        pop;

  assign unused_imm = imm[0];
  assign f7 = funct7 ? 7'b0100000 : 7'b0000000;

  always_comb begin
    enc       = '0;
    supported = 1'b1;
    case (opcode)
      OP_R:      enc = {f7, rs2, rs1, funct3, rd, opcode};
      OP_IMM: begin
        // Shift-immediates carry the funct7 class in the upper bits instead of imm[11:5]
        if (funct3 == 3'b001 || funct3 == 3'b101)
          enc = {f7, imm[4:0], rs1, funct3, rd, opcode};
        else
          enc = {imm[11:0], rs1, funct3, rd, opcode};
      end
      OP_LOAD:   enc = {imm[11:0], rs1, funct3, rd, opcode};
      OP_JALR:   enc = {imm[11:0], rs1, 3'b000, rd, opcode};
      OP_STORE:  enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      OP_BRANCH: enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      OP_AUIPC,
      OP_LUI:    enc = {imm[31:12], rd, opcode};
      OP_JAL:    enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default:   supported = 1'b0;
    endcase
  end

  assign in_ready = !rst && !flush && !ovf && (count != 2'd2);
  assign accept   = in_valid && in_ready;
  assign push     = accept && supported;
  assign wr_en    = (count != 2'd0) && !ovf;
  assign pop      = wr_en && wr_ready;
  assign wr_data  = fifo_mem[rd_ptr];

  // Once the top address is written the block freezes until flush or reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
      wr_addr     <= BASE;
      wr_count    <= '0;
      err         <= 1'b0;
      ovf         <= 1'b0;
    end else if (flush) begin
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      wr_addr  <= BASE;
      wr_count <= '0;
      err      <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= enc;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr   <= ~rd_ptr;
        wr_count <= wr_count + (ADDR_WIDTH+1)'(1);
        if (wr_addr == TOP)
          ovf <= 1'b1;
        else
          wr_addr <= wr_addr + ADDR_WIDTH'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (accept && !supported)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected writes are queued at acceptance
// and compared when the memory write completes; a 2-bit-address copy covers overflow.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        funct7;
  logic [31:0] imm;
  logic        flush;
  logic        wr_ready;

  logic        in_ready, wr_en, err, ovf;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [8:0]  wr_count;

  logic        s_in_ready, s_wr_en, s_err, s_ovf;
  logic [1:0]  s_wr_addr;
  logic [31:0] s_wr_data;
  logic [2:0]  s_wr_count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [7:0]  next_addr;
  logic [7:0]  exp_addr_q [$];
  logic [31:0] exp_data_q [$];
  logic [1:0]  small_log [$];

  instr_encoder #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .flush(flush), .wr_en(wr_en),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_count(wr_count), .err(err), .ovf(ovf)
  );

  instr_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .flush(flush), .wr_en(s_wr_en),
    .wr_ready(wr_ready), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .wr_count(s_wr_count), .err(s_err), .ovf(s_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Completed writes of the main instance are checked against the scoreboard
  always @(negedge clk) begin
    if (!rst && !flush && wr_en && wr_ready) begin
      tests++;
      if (exp_data_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL sb_unexpected: write addr %0d data %08h, none expected", wr_addr, wr_data);
      end else begin
        logic [7:0]  ea;
        logic [31:0] ed;
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        if (wr_addr !== ea || wr_data !== ed) begin
          fails++;
          $display("[TB] FAIL sb_write: got addr %0d data %08h, want addr %0d data %08h", wr_addr, wr_data, ea, ed);
        end
      end
    end
  end

  always @(negedge clk)
    if (!rst && !flush && s_wr_en && wr_ready) small_log.push_back(s_wr_addr);

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic send(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [2:0] f3, input logic f7,
                      input logic [31:0] im, input logic [31:0] exp_word);
    bit ok = 0;
    opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      tests++; fails++;
      $display("[TB] FAIL send_timeout: in_ready got 0, want 1 within 20 cycles");
      in_valid = 1'b0;
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      exp_addr_q.push_back(next_addr);
      exp_data_q.push_back(exp_word);
      next_addr++;
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    small_log.delete();
    next_addr = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; wr_ready = 1'b0;
    opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = 1'b0; imm = '0;
    next_addr = 0;
    #3;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_in_ready: got %0b want 0", in_ready); end
    tests++; if (wr_en !== 1'b0) begin fails++; $display("[TB] FAIL reset_wr_en: got %0b want 0", wr_en); end
    tests++; if (wr_addr !== 8'd0) begin fails++; $display("[TB] FAIL reset_wr_addr: got %0d want 0", wr_addr); end
    tests++; if (wr_data !== 32'd0) begin fails++; $display("[TB] FAIL reset_wr_data: got %08h want 0", wr_data); end
    tests++; if (wr_count !== 9'd0) begin fails++; $display("[TB] FAIL reset_wr_count: got %0d want 0", wr_count); end
    tests++; if (err !== 1'b0 || ovf !== 1'b0) begin fails++; $display("[TB] FAIL reset_flags: got err %0b ovf %0b want 0 0", err, ovf); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_release_ready: got %0b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_encode();
    int c0;
    wr_ready = 1'b1;
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 32'd0, 32'h002081B3);
    @(negedge clk);
    tests++; if (wr_en !== 1'b1 || wr_addr !== 8'd0) begin fails++; $display("[TB] FAIL latency: got wr_en %0b addr %0d want 1 0", wr_en, wr_addr); end
    @(posedge clk); #1;
    c0 = cyc;
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 1'b1, 32'd0, 32'h402081B3);
    send(7'b0010011, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'hFFFFFFFF, 32'hFFF00293);
    send(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 1'b0, 32'd4, 32'h0020A223);
    send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'h12345000, 32'h123452B7);
    send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'd8, 32'h00208463);
    send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'h00000800, 32'h001000EF);
    tests++; if (cyc - c0 !== 6) begin fails++; $display("[TB] FAIL throughput: got %0d cycles for 6 words want 6", cyc - c0); end
    repeat (4) begin @(posedge clk); #1; end
    tests++; if (exp_data_q.size() !== 0) begin fails++; $display("[TB] FAIL encode_drain: got %0d pending want 0", exp_data_q.size()); end
    tests++; if (wr_count !== 9'd7 || wr_en !== 1'b0) begin fails++; $display("[TB] FAIL encode_count: got count %0d wr_en %0b want 7 0", wr_count, wr_en); end
  endtask

  task automatic test_back_to_back();
    do_flush();
    wr_ready = 1'b0;
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 32'd0, 32'h002081B3);
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 1'b1, 32'd0, 32'h402081B3);
    opcode = 7'b0010011; rd = 5'd5; rs1 = 5'd0; funct3 = 3'b000; funct7 = 1'b0; imm = 32'hFFFFFFFF;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b0 || wr_en !== 1'b1 || wr_addr !== 8'd0 || wr_data !== 32'h002081B3) begin
        fails++;
        $display("[TB] FAIL full_stall: got ready %0b wr_en %0b addr %0d data %08h want 0 1 0 002081b3",
                 in_ready, wr_en, wr_addr, wr_data);
      end
    end
    @(posedge clk); #1;
    wr_ready = 1'b1;
    send(7'b0010011, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'hFFFFFFFF, 32'hFFF00293);
    repeat (4) begin @(posedge clk); #1; end
    tests++; if (exp_data_q.size() !== 0 || wr_count !== 9'd3) begin fails++; $display("[TB] FAIL b2b_drain: got pending %0d count %0d want 0 3", exp_data_q.size(), wr_count); end
  endtask

  task automatic test_unsupported();
    opcode = 7'h7F; rd = 5'd1; rs1 = 5'd1; rs2 = 5'd1; funct3 = 3'b000; imm = 32'd0;
    in_valid = 1'b1;
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL unsup_ready: got %0b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    tests++; if (err !== 1'b1 || wr_en !== 1'b0 || wr_count !== 9'd3) begin fails++; $display("[TB] FAIL unsup_err: got err %0b wr_en %0b count %0d want 1 0 3", err, wr_en, wr_count); end
    @(posedge clk); #1;
    do_flush();
    @(negedge clk);
    tests++; if (err !== 1'b0 || wr_count !== 9'd0 || wr_addr !== 8'd0) begin fails++; $display("[TB] FAIL unsup_flush: got err %0b count %0d addr %0d want 0 0 0", err, wr_count, wr_addr); end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    do_flush();
    wr_ready = 1'b1;
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 32'd0, 32'h002081B3);
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 1'b1, 32'd0, 32'h402081B3);
    send(7'b0010011, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'hFFFFFFFF, 32'hFFF00293);
    send(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 1'b0, 32'd4, 32'h0020A223);
    send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'h12345000, 32'h123452B7);
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    tests++; if (small_log.size() !== 4) begin fails++; $display("[TB] FAIL ovf_writes: got %0d writes want 4", small_log.size()); end
    for (int i = 0; i < small_log.size() && i < 4; i++) begin
      tests++;
      if (small_log[i] !== 2'(i)) begin fails++; $display("[TB] FAIL ovf_addr: write %0d got addr %0d want %0d", i, small_log[i], i); end
    end
    tests++; if (s_ovf !== 1'b1 || s_in_ready !== 1'b0 || s_wr_en !== 1'b0) begin fails++; $display("[TB] FAIL ovf_halt: got ovf %0b ready %0b wr_en %0b want 1 0 0", s_ovf, s_in_ready, s_wr_en); end
    tests++; if (s_wr_count !== 3'd4 || s_wr_addr !== 2'd3) begin fails++; $display("[TB] FAIL ovf_count: got count %0d addr %0d want 4 3", s_wr_count, s_wr_addr); end
    tests++; if (exp_data_q.size() !== 0 || wr_count !== 9'd5) begin fails++; $display("[TB] FAIL ovf_main: got pending %0d count %0d want 0 5", exp_data_q.size(), wr_count); end
    @(posedge clk); #1;
    do_flush();
    @(negedge clk);
    tests++;
    if (s_ovf !== 1'b0 || s_wr_count !== 3'd0 || s_wr_addr !== 2'd0 || s_in_ready !== 1'b1 || s_wr_en !== 1'b0 || s_err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ovf_flush: got ovf %0b count %0d addr %0d ready %0b wr_en %0b err %0b want 0 0 0 1 0 0",
               s_ovf, s_wr_count, s_wr_addr, s_in_ready, s_wr_en, s_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    do_flush();
    wr_ready = 1'b0;
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 32'd0, 32'h002081B3);
    send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'h00000800, 32'h001000EF);
    @(negedge clk);
    tests++; if (wr_en !== 1'b1) begin fails++; $display("[TB] FAIL arst_pre: got wr_en %0b want 1", wr_en); end
    #1 rst = 1'b1;
    #1;
    tests++; if (wr_en !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("[TB] FAIL arst_now: got wr_en %0b ready %0b want 0 0", wr_en, in_ready); end
    tests++; if (wr_data !== 32'd0 || wr_count !== 9'd0 || wr_addr !== 8'd0) begin fails++; $display("[TB] FAIL arst_vals: got data %08h count %0d addr %0d want 0 0 0", wr_data, wr_count, wr_addr); end
    exp_addr_q.delete();
    exp_data_q.delete();
    next_addr = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    wr_ready = 1'b1;
    @(negedge clk);
    tests++; if (wr_en !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0 || ovf !== 1'b0) begin fails++; $display("[TB] FAIL arst_after: got wr_en %0b ready %0b err %0b ovf %0b want 0 1 0 0", wr_en, in_ready, err, ovf); end
    repeat (3) begin @(posedge clk); #1; end
    tests++; if (wr_count !== 9'd0) begin fails++; $display("[TB] FAIL arst_lost: got count %0d want 0", wr_count); end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_back_to_back();
    test_unsupported();
    test_overflow();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Packs RV32I instruction fields (opcode, rd, rs1, rs2, funct3, funct7 select, immediate) into 32-bit instruction words and writes them sequentially into instruction memory. It is the encode-side counterpart of the control unit's decode: every word it emits decodes back to the same opcode/funct3/funct7 class. It sits in the program-load path between the test/boot sequencer and the instruction memory write port. A valid/ready input, a 2-entry FIFO and a stallable write port decouple the producer from the memory.

## Interface
- ADDR_WIDTH, 8, instruction-memory word-address width.
- BASE_ADDR, 0, first word address written after reset or flush.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  field bundle valid
- in_ready  out  1  block accepts the bundle this cycle
- opcode  in  7  RV32I major opcode
- rd, rs1, rs2  in  5 each  register indices
- funct3  in  3  funct3 field
- funct7  in  1  1 selects instr[31:25]=0100000 (SUB/SRA/SRAI), 0 selects 0000000
- imm  in  32  immediate, byte-offset form (B/J bit 0 ignored; U uses imm[31:12])
- flush  in  1  synchronous: clear FIFO, address, count, sticky flags
- wr_en  out  1  memory write request
- wr_ready  in  1  memory accepts write when high with wr_en
- wr_addr  out  ADDR_WIDTH  word address of current write
- wr_data  out  32  encoded instruction
- wr_count  out  ADDR_WIDTH+1  words written since reset/flush
- err  out  1  sticky: unsupported opcode accepted
- ovf  out  1  sticky: top address written, block halted

## Operation
- Encoding (combinational, from input bundle):
  - R 0110011: {f7,rs2,rs1,funct3,rd,op}, f7 = funct7 ? 0100000 : 0000000.
  - I-ALU 0010011: funct3 001/101 -> {f7,imm[4:0],rs1,funct3,rd,op}; else {imm[11:0],rs1,funct3,rd,op}.
  - Load 0000011: {imm[11:0],rs1,funct3,rd,op}. JALR 1100111: same, funct3 forced 000.
  - S 0100011: {imm[11:5],rs2,rs1,funct3,imm[4:0],op}.
  - B 1100011: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op}.
  - AUIPC 0010111 / LUI 0110111: {imm[31:12],rd,op}.
  - JAL 1101111: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
- Accept = in_valid && in_ready. Supported opcode -> push encoded word into FIFO. Any other opcode -> bundle consumed, nothing pushed, err set.
- in_ready = !rst && !flush && !ovf && (FIFO occupancy < 2). No same-cycle bypass on full.
- wr_en = FIFO non-empty && !ovf. wr_data = FIFO head. wr_addr = address counter.
- Write completes on wr_en && wr_ready: pop head, wr_addr+1, wr_count+1.
- Completion at wr_addr = 2^ADDR_WIDTH-1: ovf set, wr_addr holds at top, no further writes or accepts. Remaining FIFO entries are held until flush.
- Push and pop in the same cycle: occupancy unchanged, order preserved.
- flush has priority over push/pop in the same cycle: occupancy 0, wr_addr=BASE_ADDR, wr_count=0, err=ovf=0.

## Timing
- Reset (async) values: in_ready 0 while rst high, then 1. wr_en 0, wr_addr BASE_ADDR, wr_data 0, wr_count 0, err 0, ovf 0, FIFO empty.
- rst asserted mid-write: wr_en drops immediately, and the pending word is lost.
- Latency: bundle accepted at edge N -> wr_en high in cycle after N. With wr_ready tied high, write completes at edge N+1.
- Sustained throughput: 1 word/cycle with wr_ready high.
- wr_addr/wr_data stable while wr_en && !wr_ready.
- err is set at the accepting edge. ovf is set at the completing edge.

## Test plan
- add x3,x1,x2 (op 0110011, f3 0, funct7 0), wr_ready=1 -> one write, addr 0, data 0x002081B3. Same with funct7=1 -> 0x402081B3 at addr 1.
- addi x5,x0,imm=0xFFFFFFFF -> 0xFFF00293. sw x2,4(x1) -> 0x0020A223. lui x5,imm=0x12345000 -> 0x123452B7.
- beq x1,x2,imm=8 -> 0x00208463. jal x1,imm=0x800 -> 0x001000EF. Checks B/J bit scrambling.
- wr_ready=0, 3 back-to-back valid bundles -> in_ready falls after 2 accepts. Release wr_ready -> words written in order, addr 0,1, then third accepted and written at addr 2.
- ADDR_WIDTH=2, stream 5 words with wr_ready=1 -> writes at addr 0..3, ovf=1 after 4th, in_ready=0, wr_count=4. Then flush -> all cleared, addr 0.
- opcode 0x7F with in_valid -> accepted, no wr_en, err=1. Async rst pulse with 2 queued words -> wr_en 0 immediately, FIFO empty, all outputs at reset values.
